min4_tracker: RTL and testbench
===============================

# min4_tracker

Streaming running-minimum tracker. Accepts a frame of 10-bit candidate metrics, two per beat, and keeps the four smallest values seen so far in ascending order. Each beat is merged into the held list through the existing `insertion_sort` network, and the lower four of its six outputs are kept. After the last beat of a frame, the sorted four-entry result and a beat count are presented on an output handshake for the downstream selection stage.

## Interface
- `FILL_VAL`, default `10'h3FF`: value loaded into every list entry at frame start. It acts as the "empty" marker.
- `CNT_W`, default `8`: width of the saturating beat counter.

Ports:
- `i_clk` in 1: the single clock.
- `i_rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `i_in_valid` in 1: input beat valid.
- `o_in_ready` out 1: input beat accepted when `i_in_valid & o_in_ready`.
- `i_in_data_0` in 10: first candidate of the pair.
- `i_in_data_1` in 10: second candidate of the pair.
- `i_in_last` in 1: marks the final beat of the frame.
- `o_out_valid` out 1: result valid.
- `i_out_ready` in 1: result consumed when `o_out_valid & i_out_ready`.
- `o_out_data_0`..`o_out_data_3` out 10 each: result list, ascending (`_0` is the smallest).
- `o_out_cnt` out `CNT_W`: number of beats in the frame, saturating at `2^CNT_W-1`.

## Operation
- Two states:
  - `ACC`: accumulating. `o_in_ready=1`, `o_out_valid=0`.
  - `OUT`: result held. `o_in_ready=0`, `o_out_valid=1`.
- Reset state: `ACC`.
  - List registers `L0..L3` = `FILL_VAL`.
  - Count = 0.
  - All outputs 0, except `o_in_ready=1`.
- On an accepted beat in `ACC`:
  - The input pair is ordered low/high (see Configuration).
  - `{L0..L3}` and the ordered pair feed `insertion_sort`.
  - `L0..L3` take sorted outputs 0..3. Outputs 4..5 are discarded.
  - Count increments, saturating at its maximum.
- If the accepted beat has `i_in_last=1`: the next state is `OUT`, and `o_out_data_*` / `o_out_cnt` are registered from the post-merge list and count.
- In `OUT`, outputs stay stable until the handshake completes. After the handshake:
  - Next state is `ACC`.
  - `L0..L3` reload `FILL_VAL`.
  - Count clears.
  - `o_out_data_*` and `o_out_cnt` hold their last value. They are don't-care while `o_out_valid=0`.
- Ties use strict less-than: a new value equal to a held value is placed after it, so earlier entries win.
- A frame shorter than two beats (fewer than four real values) leaves the unused tail entries at `FILL_VAL`.
- Candidates equal to `FILL_VAL` are legal and indistinguishable from empty entries.
- `i_in_*` is ignored while `o_in_ready=0`. Upstream holds the beat.
- Asynchronous reset mid-frame or in `OUT` discards all state, including a pending result.

## Timing
- Merge is single-cycle combinational from `L*` and the inputs into `L*`. One beat per cycle is sustained in `ACC`.
- Latency: `o_out_valid` rises on the clock edge that accepts the `last` beat, i.e. it is visible the cycle after that beat.
- Minimum frame period: N beats + 1 cycle, with `i_out_ready` held at 1.
  - `OUT` lasts at least one cycle.
  - There is no accept of a new input beat in the same cycle as the output handshake.
- `o_out_valid` must not drop and `o_out_data_*` must not change before the handshake.

## Configuration
- `MIN4_PAIR_SORT_EN`, when defined:
  - A compare-swap orders the pair before the merge, so either order is legal.
  - On equality, `i_in_data_0` is taken first.
- When not defined:
  - No compare-swap is built.
  - Upstream must guarantee `i_in_data_0 <= i_in_data_1`.
  - A violating beat gives an unspecified list order.
  - The assertion-based bench flags it.

## Structure
- Shared package holds:
  - `DATA_W=10`.
  - `LIST_N=4`.
  - The state enum (`ACC`, `OUT`).
  - The default `FILL_VAL`.
- Sub-module: one `insertion_sort` instance (4 sorted + 2 sorted → 6 sorted) forms the merge datapath. The control FSM, counter and pair compare-swap stay in `min4_tracker`.

## Test plan
- Single beat, last: (7,3) with `MIN4_PAIR_SORT_EN` defined → output `3,7,3FF,3FF`, cnt=1, valid the cycle after accept.
- Three beats: (9,20), (1,15), (4,4), last → `1,4,4,9`, cnt=3. Outputs 15 and 20 are dropped.
- Backpressure: hold `i_out_ready=0` for 5 cycles → valid and data stable, `o_in_ready=0`. Then `ready=1` → `o_in_ready=1` on the next cycle and the list is reset to `3FF`.
- Back-to-back frames with ready tied high: the second frame's result is unaffected by the first. Example: frame A (2,3) gives `2,3,3FF,3FF`, then frame B (50,60) gives `50,60,3FF,3FF`.
- Saturation: 300 beats of (5,6) → `5,5,5,5`, cnt=255.
- Reset asserted mid-frame after (0,1) → outputs 0, `o_in_ready=1`. A following frame (8,9) gives `8,9,3FF,3FF`, cnt=1.

Source files
------------

// File: rtl/min4_tracker_pkg.sv
// Shared types and constants for the min4_tracker running-minimum block.
// Holds list geometry, the empty-entry marker and the control state enum.
package min4_tracker_pkg;

    localparam int DATA_W = 10;
    localparam int LIST_N = 4;

    localparam logic [DATA_W-1:0] FILL_VAL_DEF = 10'h3FF;

    typedef enum logic {
        ACC,
        OUT
    } state_t;

endpackage

// File: rtl/insertion_sort.sv
// Merge network: a sorted 4-entry list plus a sorted pair into a sorted 6-list.
// Held entries win ties, so a new value equal to a held one lands after it.
module insertion_sort
    import min4_tracker_pkg::*;
(
    input  logic [LIST_N-1:0][DATA_W-1:0] held,
    input  logic [1:0][DATA_W-1:0]        pair,
    output logic [LIST_N+1:0][DATA_W-1:0] sorted
);

    // Rank every element by how many of the other list precede it, then scatter.
    always_comb begin
        logic [2:0] rank;
        sorted = '0;
        for (int i = 0; i < LIST_N; i++) begin
            rank = 3'(i);
            for (int j = 0; j < 2; j++) begin
                if (pair[j] < held[i]) rank = rank + 3'd1;
            end
            sorted[rank] = sorted[rank] | held[i];
        end
        for (int j = 0; j < 2; j++) begin
            rank = 3'(j);
            for (int i = 0; i < LIST_N; i++) begin
                if (held[i] <= pair[j]) rank = rank + 3'd1;
            end
            sorted[rank] = sorted[rank] | pair[j];
        end
    end

endmodule

// File: rtl/min4_tracker.sv
// Streaming tracker keeping the four smallest metrics of a frame, two per beat.
// Define MIN4_PAIR_SORT_EN to build a compare-swap that orders each input pair.
module min4_tracker
    import min4_tracker_pkg::*;
#(
    parameter logic [DATA_W-1:0] FILL_VAL = FILL_VAL_DEF,
    parameter int                CNT_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data_0,
    input  logic [DATA_W-1:0] i_in_data_1,
    input  logic              i_in_last,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data_0,
    output logic [DATA_W-1:0] o_out_data_1,
    output logic [DATA_W-1:0] o_out_data_2,
    output logic [DATA_W-1:0] o_out_data_3,
    output logic [CNT_W-1:0]  o_out_cnt
);

    state_t                        state;
    logic [LIST_N-1:0][DATA_W-1:0] list_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [CNT_W-1:0]              cnt_nxt;
    logic [DATA_W-1:0]             pair_lo;
    logic [DATA_W-1:0]             pair_hi;
    logic [LIST_N+1:0][DATA_W-1:0] merged;
    logic                          unused_tail;

    // Order the incoming pair low/high before it enters the merge network.
    always_comb begin
`ifdef MIN4_PAIR_SORT_EN
        if (i_in_data_1 < i_in_data_0) begin
            pair_lo = i_in_data_1;
            pair_hi = i_in_data_0;
        end else begin
            pair_lo = i_in_data_0;
            pair_hi = i_in_data_1;
        end
`else
        pair_lo = i_in_data_0;
        pair_hi = i_in_data_1;
`endif
    end

    assign cnt_nxt = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    insertion_sort u_sort (
        .held   (list_q),
        .pair   ({pair_hi, pair_lo}),
        .sorted (merged)
    );

    // The two largest merged values never survive into the list.
    assign unused_tail = ^merged[LIST_N+1:LIST_N];

    // Control FSM with registered handshake flags and result capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ACC;
            list_q       <= {LIST_N{FILL_VAL}};
            cnt_q        <= '0;
            o_in_ready   <= 1'b1;
            o_out_valid  <= 1'b0;
            o_out_data_0 <= '0;
            o_out_data_1 <= '0;
            o_out_data_2 <= '0;
            o_out_data_3 <= '0;
            o_out_cnt    <= '0;
        end else begin
            unique case (state)
                ACC: begin
                    if (i_in_valid) begin
                        list_q <= merged[LIST_N-1:0];
                        cnt_q  <= cnt_nxt;
                        if (i_in_last) begin
                            state        <= OUT;
                            o_in_ready   <= 1'b0;
                            o_out_valid  <= 1'b1;
                            o_out_data_0 <= merged[0];
                            o_out_data_1 <= merged[1];
                            o_out_data_2 <= merged[2];
                            o_out_data_3 <= merged[3];
                            o_out_cnt    <= cnt_nxt;
                        end
                    end
                end
                OUT: begin
                    if (i_out_ready) begin
                        state       <= ACC;
                        list_q      <= {LIST_N{FILL_VAL}};
                        cnt_q       <= '0;
                        o_in_ready  <= 1'b1;
                        o_out_valid <= 1'b0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_min4_tracker.sv
// Directed bench for min4_tracker: merge, ties, backpressure, saturation, reset.
// Expected lists are hand-computed; comparisons are immediate assertions.
module tb_min4_tracker;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_in_valid;
    logic       o_in_ready;
    logic [9:0] i_in_data_0;
    logic [9:0] i_in_data_1;
    logic       i_in_last;
    logic       o_out_valid;
    logic       i_out_ready;
    logic [9:0] o_out_data_0;
    logic [9:0] o_out_data_1;
    logic [9:0] o_out_data_2;
    logic [9:0] o_out_data_3;
    logic [7:0] o_out_cnt;

    int checks = 0;
    int errors = 0;

    min4_tracker dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_in_data_0  (i_in_data_0),
        .i_in_data_1  (i_in_data_1),
        .i_in_last    (i_in_last),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data_0 (o_out_data_0),
        .o_out_data_1 (o_out_data_1),
        .o_out_data_2 (o_out_data_2),
        .o_out_data_3 (o_out_data_3),
        .o_out_cnt    (o_out_cnt)
    );

    always #5 i_clk = ~i_clk;

`ifndef MIN4_PAIR_SORT_EN
    // Without the compare-swap the upstream must present ordered pairs.
    always @(posedge i_clk) begin
        if (i_rst_n && i_in_valid && o_in_ready && (i_in_data_0 > i_in_data_1)) begin
            errors++;
            $error("FAIL pair_order: observed %0h>%0h required d0<=d1",
                   i_in_data_0, i_in_data_1);
        end
    end
`endif

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int e0, input int e1,
                           input int e2, input int e3, input int ec);
        chk({tag, "_valid"}, int'(o_out_valid), 1);
        chk({tag, "_inrdy"}, int'(o_in_ready), 0);
        chk({tag, "_d0"}, int'(o_out_data_0), e0);
        chk({tag, "_d1"}, int'(o_out_data_1), e1);
        chk({tag, "_d2"}, int'(o_out_data_2), e2);
        chk({tag, "_d3"}, int'(o_out_data_3), e3);
        chk({tag, "_cnt"}, int'(o_out_cnt), ec);
    endtask

    task automatic beat(input logic [9:0] a, input logic [9:0] b, input logic last);
        i_in_valid  = 1'b1;
        i_in_data_0 = a;
        i_in_data_1 = b;
        i_in_last   = last;
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
    endtask

    task automatic handshake(input string tag);
        i_out_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_out_ready = 1'b0;
        chk({tag, "_hs_valid"}, int'(o_out_valid), 0);
        chk({tag, "_hs_inrdy"}, int'(o_in_ready), 1);
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_in_valid  = 1'b0;
        i_in_data_0 = '0;
        i_in_data_1 = '0;
        i_in_last   = 1'b0;
        i_out_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", int'(o_out_valid), 0);
        chk("rst_inrdy", int'(o_in_ready), 1);
        chk("rst_d0", int'(o_out_data_0), 0);
        chk("rst_d3", int'(o_out_data_3), 0);
        chk("rst_cnt", int'(o_out_cnt), 0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Single beat, last
`ifdef MIN4_PAIR_SORT_EN
        beat(10'd7, 10'd3, 1'b1);
`else
        beat(10'd3, 10'd7, 1'b1);
`endif
        chk_res("single", 3, 7, 'h3FF, 'h3FF, 1);
        handshake("single");

        // Three beats; 15 and 20 fall off the end
        beat(10'd9, 10'd20, 1'b0);
        chk("three_mid_valid", int'(o_out_valid), 0);
        beat(10'd1, 10'd15, 1'b0);
        beat(10'd4, 10'd4, 1'b1);
        chk_res("three", 1, 4, 4, 9, 3);

        // Backpressure with a junk beat offered that must be ignored
        i_in_valid  = 1'b1;
        i_in_data_0 = 10'd0;
        i_in_data_1 = 10'd0;
        i_in_last   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk);
            #1;
            chk_res("bp", 1, 4, 4, 9, 3);
        end
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
        handshake("bp");
        beat(10'd100, 10'd200, 1'b1);
        chk_res("after_bp", 100, 200, 'h3FF, 'h3FF, 1);
        handshake("after_bp");

        // Back-to-back frames with ready tied high
        i_out_ready = 1'b1;
        beat(10'd2, 10'd3, 1'b1);
        chk_res("b2b_a", 2, 3, 'h3FF, 'h3FF, 1);
        i_in_valid  = 1'b1;
        i_in_data_0 = 10'd50;
        i_in_data_1 = 10'd60;
        i_in_last   = 1'b1;
        @(posedge i_clk);
        #1;
        chk("b2b_gap_valid", int'(o_out_valid), 0);
        chk("b2b_gap_inrdy", int'(o_in_ready), 1);
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
        chk_res("b2b_b", 50, 60, 'h3FF, 'h3FF, 1);
        @(posedge i_clk);
        #1;
        i_out_ready = 1'b0;
        chk("b2b_end_valid", int'(o_out_valid), 0);

        // Saturating count over 300 beats
        for (int k = 0; k < 299; k++) beat(10'd5, 10'd6, 1'b0);
        beat(10'd5, 10'd6, 1'b1);
        chk_res("sat", 5, 5, 5, 5, 255);
        handshake("sat");

        // Asynchronous reset mid-frame
        beat(10'd0, 10'd1, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mrst_valid", int'(o_out_valid), 0);
        chk("mrst_inrdy", int'(o_in_ready), 1);
        chk("mrst_d0", int'(o_out_data_0), 0);
        chk("mrst_cnt", int'(o_out_cnt), 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        beat(10'd8, 10'd9, 1'b1);
        chk_res("post_rst", 8, 9, 'h3FF, 'h3FF, 1);
        handshake("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
